// File: rtl/sd_host_regs_pkg.sv
// Shared register map, status bit positions and software-reset state encoding
// for the SD host register bank.
package sd_host_regs_pkg;

  // Word addresses of the host-visible registers
  localparam int unsigned ADDR_BLOCK_SIZE              = 0;
  localparam int unsigned ADDR_BLOCK_COUNT             = 1;
  localparam int unsigned ADDR_ARGUMENT                = 2;
  localparam int unsigned ADDR_TRANSFER_MODE           = 3;
  localparam int unsigned ADDR_COMMAND                 = 4;
  localparam int unsigned ADDR_TIMEOUT_CONTROL         = 5;
  localparam int unsigned ADDR_SOFTWARE_RESET          = 6;
  localparam int unsigned ADDR_PRESENT_STATE           = 7;
  localparam int unsigned ADDR_NORMAL_INT_STATUS       = 8;
  localparam int unsigned ADDR_ERROR_INT_STATUS        = 9;
  localparam int unsigned ADDR_NORMAL_INT_STATUS_EN    = 10;
  localparam int unsigned ADDR_ERROR_INT_STATUS_EN     = 11;
  localparam int unsigned ADDR_NORMAL_INT_SIGNAL_EN    = 12;
  localparam int unsigned ADDR_ERROR_INT_SIGNAL_EN     = 13;
  localparam int unsigned ADDR_HOST_CONTROLLER_VERSION = 14;
  localparam int unsigned ADDR_RESPONSE_BASE           = 16;

  // Normal interrupt status bit positions and groups
  localparam int unsigned NSTAT_CMD_COMPLETE  = 0;
  localparam int unsigned NSTAT_ERR_SUMMARY   = 15;
  localparam logic [15:0] NSTAT_CMD_LINE_MASK = 16'h0001;
  localparam logic [15:0] NSTAT_DAT_LINE_MASK = 16'h003E;
  localparam logic [15:0] NSTAT_SETTABLE_MASK = 16'h7FFF;

  // Error interrupt status bit positions
  localparam int unsigned ESTAT_CMD_TIMEOUT = 0;
  localparam int unsigned ESTAT_CMD_CRC     = 1;
  localparam int unsigned ESTAT_CMD_END_BIT = 2;
  localparam int unsigned ESTAT_CMD_INDEX   = 3;

  // Software reset request bits
  localparam int unsigned SWRST_ALL = 0;
  localparam int unsigned SWRST_CMD = 1;
  localparam int unsigned SWRST_DAT = 2;

  typedef enum logic {
    SWRST_IDLE   = 1'b0,
    SWRST_ACTIVE = 1'b1
  } swrst_state_e;

endpackage

// File: rtl/sd_host_register_bank_irq.sv
// 16-bit interrupt status register: enabled events set bits, host writes of 1
// clear them, a set in the same cycle as a clear wins; flush_i clears
// unconditionally (software reset).
module sd_irq_status_reg (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] event_i,
  input  logic [15:0] enable_i,
  input  logic [15:0] w1c_i,
  input  logic [15:0] flush_i,
  output logic [15:0] status_o
);

  logic [15:0] status_q;
  logic [15:0] status_d;

  // Next status: keep uncleared bits, OR in enabled events, then apply flush
  always_comb begin
    status_d = ((status_q & ~w1c_i) | (event_i & enable_i)) & ~flush_i;
  end

  // Status storage
  always_ff @(posedge clk_i) begin
    if (!rst_ni) status_q <= '0;
    else         status_q <= status_d;
  end

  always_comb status_o = status_q;

endmodule

// File: rtl/sd_host_register_bank.sv
// SD host controller register bank: byte-enabled configuration registers,
// multi-word response readback, W1C interrupt status, registered interrupt,
// command-start pulse and self-clearing software reset.
module sd_host_register_bank
  import sd_host_regs_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADR_W        = 5,
  parameter int unsigned RESP_W       = 128,
  parameter logic [15:0] HC_VERSION   = 16'h0002,
  parameter int unsigned SWRST_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADR_W-1:0]    adr_i,
  input  logic                reg_write_en,
  input  logic                reg_read_en,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                command_complete,
  input  logic [RESP_W-1:0]   response_i,
  input  logic [15:0]         normal_interrupt_event_i,
  input  logic [15:0]         error_interrupt_event_i,
  input  logic [15:0]         present_state_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                read_valid,
  output logic [11:0]         block_size,
  output logic [15:0]         block_count,
  output logic [31:0]         argument,
  output logic [15:0]         transfer_mode,
  output logic [15:0]         command,
  output logic                command_start,
  output logic [15:0]         timeout_control,
  output logic [2:0]          software_reset,
  output logic [15:0]         error_interrupt_status_o,
  output logic                interrupt
);

  localparam int unsigned NRESP = RESP_W / DATA_W;
  localparam int unsigned CNT_W = $clog2(SWRST_CYCLES + 1);

  logic [11:0]       blk_size_q;
  logic [15:0]       blk_cnt_q, xfer_q, cmd_q, tmo_q;
  logic [31:0]       arg_q;
  logic [15:0]       nsen_q, esen_q, nsig_q, esig_q;
  logic [RESP_W-1:0] resp_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, cmd_start_q, irq_q;

  logic [DATA_W-1:0] wmask;
  logic [15:0]       nevent, nclr, nflush, eclr, eflush;
  logic [15:0]       nstat_raw, nstat, estat;

  swrst_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        swrst_q, swrst_d;
  logic              swrst_req, swrst_done, swrst_all;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                              input logic [DATA_W-1:0] new_v,
                                              input logic [DATA_W-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Expand byte enables into a bit mask
  always_comb begin
    wmask = '0;
    for (int unsigned b = 0; b < DATA_W / 8; b++) wmask[b*8 +: 8] = {8{byte_en[b]}};
  end

  // Host-writable configuration registers; a full software reset clears them
  always_ff @(posedge clock) begin
    if (!reset || swrst_all) begin
      blk_size_q <= '0;
      blk_cnt_q  <= '0;
      arg_q      <= '0;
      xfer_q     <= '0;
      cmd_q      <= '0;
      tmo_q      <= '0;
      nsen_q     <= '0;
      esen_q     <= '0;
      nsig_q     <= '0;
      esig_q     <= '0;
    end else if (reg_write_en) begin
      case (adr_i)
        ADR_W'(ADDR_BLOCK_SIZE):           blk_size_q <= 12'(merge(DATA_W'(blk_size_q), data_i, wmask));
        ADR_W'(ADDR_BLOCK_COUNT):          blk_cnt_q  <= 16'(merge(DATA_W'(blk_cnt_q), data_i, wmask));
        ADR_W'(ADDR_ARGUMENT):             arg_q      <= 32'(merge(DATA_W'(arg_q), data_i, wmask));
        ADR_W'(ADDR_TRANSFER_MODE):        xfer_q     <= 16'(merge(DATA_W'(xfer_q), data_i, wmask));
        ADR_W'(ADDR_COMMAND): if (!present_state_i[0])
                                           cmd_q      <= 16'(merge(DATA_W'(cmd_q), data_i, wmask));
        ADR_W'(ADDR_TIMEOUT_CONTROL):      tmo_q      <= 16'(merge(DATA_W'(tmo_q), data_i, wmask));
        ADR_W'(ADDR_NORMAL_INT_STATUS_EN): nsen_q     <= 16'(merge(DATA_W'(nsen_q), data_i, wmask));
        ADR_W'(ADDR_ERROR_INT_STATUS_EN):  esen_q     <= 16'(merge(DATA_W'(esen_q), data_i, wmask));
        ADR_W'(ADDR_NORMAL_INT_SIGNAL_EN): nsig_q     <= 16'(merge(DATA_W'(nsig_q), data_i, wmask));
        ADR_W'(ADDR_ERROR_INT_SIGNAL_EN):  esig_q     <= 16'(merge(DATA_W'(esig_q), data_i, wmask));
        default: ;
      endcase
    end
  end

  // Card response is captured only on command completion
  always_ff @(posedge clock) begin
    if (!reset)                resp_q <= '0;
    else if (command_complete) resp_q <= response_i;
  end

  // Status set/clear/flush vectors for both status registers
  always_comb begin
    nevent    = normal_interrupt_event_i;
    nevent[NSTAT_CMD_COMPLETE] = normal_interrupt_event_i[NSTAT_CMD_COMPLETE] | command_complete;
    nclr      = '0;
    eclr      = '0;
    if (reg_write_en && adr_i == ADR_W'(ADDR_NORMAL_INT_STATUS)) nclr = data_i[15:0] & wmask[15:0];
    if (reg_write_en && adr_i == ADR_W'(ADDR_ERROR_INT_STATUS))  eclr = data_i[15:0] & wmask[15:0];
    nflush    = '0;
    if (swrst_done && swrst_q[SWRST_CMD]) nflush = nflush | NSTAT_CMD_LINE_MASK;
    if (swrst_done && swrst_q[SWRST_DAT]) nflush = nflush | NSTAT_DAT_LINE_MASK;
    if (swrst_all) nflush = '1;
    eflush    = {16{swrst_all}};
  end

  // Bit 15 is the error summary, so it is never set through the enable path
  sd_irq_status_reg u_normal_status (
    .clk_i    (clock),
    .rst_ni   (reset),
    .event_i  (nevent),
    .enable_i (nsen_q & NSTAT_SETTABLE_MASK),
    .w1c_i    (nclr),
    .flush_i  (nflush),
    .status_o (nstat_raw)
  );

  sd_irq_status_reg u_error_status (
    .clk_i    (clock),
    .rst_ni   (reset),
    .event_i  (error_interrupt_event_i),
    .enable_i (esen_q),
    .w1c_i    (eclr),
    .flush_i  (eflush),
    .status_o (estat)
  );

  // Host view of normal status with the live error summary in bit 15
  always_comb begin
    nstat = nstat_raw;
    nstat[NSTAT_ERR_SUMMARY] = nstat_raw[NSTAT_ERR_SUMMARY] | (|estat);
  end

  // Read data mux; narrow registers zero-extend, unmapped addresses read 0
  always_comb begin
    rdata_d = '0;
    case (adr_i)
      ADR_W'(ADDR_BLOCK_SIZE):              rdata_d = DATA_W'(blk_size_q);
      ADR_W'(ADDR_BLOCK_COUNT):             rdata_d = DATA_W'(blk_cnt_q);
      ADR_W'(ADDR_ARGUMENT):                rdata_d = DATA_W'(arg_q);
      ADR_W'(ADDR_TRANSFER_MODE):           rdata_d = DATA_W'(xfer_q);
      ADR_W'(ADDR_COMMAND):                 rdata_d = DATA_W'(cmd_q);
      ADR_W'(ADDR_TIMEOUT_CONTROL):         rdata_d = DATA_W'(tmo_q);
      ADR_W'(ADDR_SOFTWARE_RESET):          rdata_d = DATA_W'(swrst_q);
      ADR_W'(ADDR_PRESENT_STATE):           rdata_d = DATA_W'(present_state_i);
      ADR_W'(ADDR_NORMAL_INT_STATUS):       rdata_d = DATA_W'(nstat);
      ADR_W'(ADDR_ERROR_INT_STATUS):        rdata_d = DATA_W'(estat);
      ADR_W'(ADDR_NORMAL_INT_STATUS_EN):    rdata_d = DATA_W'(nsen_q);
      ADR_W'(ADDR_ERROR_INT_STATUS_EN):     rdata_d = DATA_W'(esen_q);
      ADR_W'(ADDR_NORMAL_INT_SIGNAL_EN):    rdata_d = DATA_W'(nsig_q);
      ADR_W'(ADDR_ERROR_INT_SIGNAL_EN):     rdata_d = DATA_W'(esig_q);
      ADR_W'(ADDR_HOST_CONTROLLER_VERSION): rdata_d = DATA_W'(HC_VERSION);
      default: ;
    endcase
    for (int unsigned k = 0; k < NRESP; k++) begin
      if (adr_i == ADR_W'(ADDR_RESPONSE_BASE + k)) rdata_d = resp_q[k*DATA_W +: DATA_W];
    end
  end

  // Read handshake, command-start pulse and registered interrupt
  always_ff @(posedge clock) begin
    if (!reset) begin
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      cmd_start_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      rvalid_q    <= reg_read_en && !reg_write_en;
      if (reg_read_en && !reg_write_en) rdata_q <= rdata_d;
      cmd_start_q <= reg_write_en && adr_i == ADR_W'(ADDR_COMMAND) && !present_state_i[0];
      irq_q       <= (|(nstat & nsig_q)) | (|(estat & esig_q));
    end
  end

  always_comb begin
    swrst_req = reg_write_en && adr_i == ADR_W'(ADDR_SOFTWARE_RESET) &&
                byte_en[0] && (data_i[2:0] != 3'b000);
  end

  // Software reset FSM: state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= SWRST_IDLE;
      cnt_q   <= '0;
      swrst_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      swrst_q <= swrst_d;
    end
  end

  // Software reset FSM: next state; exits on the edge where the count would hit 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    swrst_d = swrst_q;
    case (state_q)
      SWRST_IDLE: begin
        if (swrst_req) begin
          state_d = SWRST_ACTIVE;
          cnt_d   = CNT_W'(SWRST_CYCLES);
          swrst_d = data_i[2:0];
        end
      end
      SWRST_ACTIVE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = SWRST_IDLE;
          cnt_d   = '0;
          swrst_d = '0;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = SWRST_IDLE;
    endcase
  end

  // Software reset FSM: outputs
  always_comb begin
    swrst_done = (state_q == SWRST_ACTIVE) && (cnt_q == CNT_W'(1));
    swrst_all  = swrst_done && swrst_q[SWRST_ALL];
  end

  always_comb begin
    data_o                   = rdata_q;
    read_valid               = rvalid_q;
    block_size               = blk_size_q;
    block_count              = blk_cnt_q;
    argument                 = arg_q;
    transfer_mode            = xfer_q;
    command                  = cmd_q;
    command_start            = cmd_start_q;
    timeout_control          = tmo_q;
    software_reset           = swrst_q;
    error_interrupt_status_o = estat;
    interrupt                = irq_q;
  end

endmodule

// File: tb/tb_sd_host_register_bank.sv
module tb_sd_host_register_bank;
  import sd_host_regs_pkg::*;

  localparam int SWC = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [4:0]   adr_i;
  logic         reg_write_en, reg_read_en;
  logic [3:0]   byte_en;
  logic [31:0]  data_i;
  logic         command_complete;
  logic [127:0] response_i;
  logic [15:0]  normal_interrupt_event_i, error_interrupt_event_i, present_state_i;
  logic [31:0]  data_o;
  logic         read_valid;
  logic [11:0]  block_size;
  logic [15:0]  block_count, transfer_mode, command, timeout_control, error_interrupt_status_o;
  logic [31:0]  argument;
  logic         command_start, interrupt;
  logic [2:0]   software_reset;

  always #5 clock = ~clock;

  sd_host_register_bank #(
    .DATA_W(32), .ADR_W(5), .RESP_W(128), .HC_VERSION(16'h0002), .SWRST_CYCLES(SWC)
  ) dut (
    .clock(clock), .reset(reset), .adr_i(adr_i), .reg_write_en(reg_write_en),
    .reg_read_en(reg_read_en), .byte_en(byte_en), .data_i(data_i),
    .command_complete(command_complete), .response_i(response_i),
    .normal_interrupt_event_i(normal_interrupt_event_i),
    .error_interrupt_event_i(error_interrupt_event_i), .present_state_i(present_state_i),
    .data_o(data_o), .read_valid(read_valid), .block_size(block_size),
    .block_count(block_count), .argument(argument), .transfer_mode(transfer_mode),
    .command(command), .command_start(command_start), .timeout_control(timeout_control),
    .software_reset(software_reset), .error_interrupt_status_o(error_interrupt_status_o),
    .interrupt(interrupt)
  );

  int tests = 0;
  int fails = 0;
  bit mon_en = 0;
  logic [31:0] exp_q[$];

  // Reference model state
  logic [31:0]  m_cfg [0:31];
  logic [15:0]  m_nst, m_est;
  logic [127:0] m_resp;
  logic [2:0]   m_sw;
  int           m_left;
  logic         m_cs, m_irq;
  logic [31:0]  m_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] width_of(input int a);
    case (a)
      ADDR_BLOCK_SIZE: return 32'h0000_0FFF;
      ADDR_ARGUMENT:   return 32'hFFFF_FFFF;
      ADDR_BLOCK_COUNT, ADDR_TRANSFER_MODE, ADDR_COMMAND, ADDR_TIMEOUT_CONTROL,
      ADDR_NORMAL_INT_STATUS_EN, ADDR_ERROR_INT_STATUS_EN,
      ADDR_NORMAL_INT_SIGNAL_EN, ADDR_ERROR_INT_SIGNAL_EN: return 32'h0000_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [15:0] m_nview();
    return {(m_est != 16'h0), m_nst[14:0]};
  endfunction

  function automatic logic [31:0] m_read(input int a, input logic [15:0] ps);
    if (width_of(a) != 0) return m_cfg[a];
    if (a == ADDR_NORMAL_INT_STATUS) return {16'h0, m_nview()};
    if (a == ADDR_ERROR_INT_STATUS) return {16'h0, m_est};
    if (a == ADDR_PRESENT_STATE) return {16'h0, ps};
    if (a == ADDR_HOST_CONTROLLER_VERSION) return 32'h0000_0002;
    if (a == ADDR_SOFTWARE_RESET) return {29'h0, m_sw};
    if (a >= ADDR_RESPONSE_BASE && a < ADDR_RESPONSE_BASE + 4)
      return m_resp[(a - ADDR_RESPONSE_BASE) * 32 +: 32];
    return 32'h0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    logic [31:0] bm;
    logic [15:0] nev, nclr, eclr;
    int a;
    bit leave;
    a = int'(adr_i);
    if (!reset) begin
      foreach (m_cfg[i]) m_cfg[i] = '0;
      m_nst = '0; m_est = '0; m_resp = '0; m_sw = '0; m_left = 0;
      m_cs = 0; m_irq = 0; m_last = '0;
      exp_q.delete();
      return;
    end
    if (reg_read_en && !reg_write_en) exp_q.push_back(m_read(a, present_state_i));
    m_irq = ((m_nview() & m_cfg[ADDR_NORMAL_INT_SIGNAL_EN][15:0]) != 0) ||
            ((m_est & m_cfg[ADDR_ERROR_INT_SIGNAL_EN][15:0]) != 0);
    m_cs = reg_write_en && a == ADDR_COMMAND && !present_state_i[0];
    for (int b = 0; b < 4; b++) bm[b*8 +: 8] = {8{byte_en[b]}};
    nev = normal_interrupt_event_i;
    nev[0] = nev[0] | command_complete;
    nev[15] = 1'b0;
    nclr = (reg_write_en && a == ADDR_NORMAL_INT_STATUS) ? data_i[15:0] & bm[15:0] : 16'h0;
    eclr = (reg_write_en && a == ADDR_ERROR_INT_STATUS)  ? data_i[15:0] & bm[15:0] : 16'h0;
    m_nst = (m_nst & ~nclr) | (nev & m_cfg[ADDR_NORMAL_INT_STATUS_EN][15:0]);
    m_est = (m_est & ~eclr) | (error_interrupt_event_i & m_cfg[ADDR_ERROR_INT_STATUS_EN][15:0]);
    if (reg_write_en && width_of(a) != 0 && !(a == ADDR_COMMAND && present_state_i[0]))
      m_cfg[a] = ((m_cfg[a] & ~bm) | (data_i & bm)) & width_of(a);
    if (command_complete) m_resp = response_i;
    leave = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) leave = 1;
    end else if (reg_write_en && a == ADDR_SOFTWARE_RESET && byte_en[0] && data_i[2:0] != 3'b000) begin
      m_sw = data_i[2:0];
      m_left = SWC;
    end
    if (leave) begin
      if (m_sw[0]) begin
        foreach (m_cfg[i]) m_cfg[i] = '0;
        m_nst = '0; m_est = '0;
      end
      if (m_sw[1]) m_nst[0] = 1'b0;
      if (m_sw[2]) m_nst[5:1] = 5'h0;
      m_sw = '0;
    end
  endtask

  // Monitor: pops the scoreboard whenever a read is due and checks live outputs
  always @(negedge clock) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        check("read_valid", read_valid, 1'b1);
        m_last = exp_q.pop_front();
        check("read_data", data_o, m_last);
      end else begin
        check("read_valid_idle", read_valid, 1'b0);
        check("data_hold", data_o, m_last);
      end
      check("command_start", command_start, m_cs);
      check("interrupt", interrupt, m_irq);
      check("software_reset", software_reset, m_sw);
      check("block_size", block_size, m_cfg[ADDR_BLOCK_SIZE]);
      check("block_count", block_count, m_cfg[ADDR_BLOCK_COUNT]);
      check("argument", argument, m_cfg[ADDR_ARGUMENT]);
      check("transfer_mode", transfer_mode, m_cfg[ADDR_TRANSFER_MODE]);
      check("command", command, m_cfg[ADDR_COMMAND]);
      check("timeout_control", timeout_control, m_cfg[ADDR_TIMEOUT_CONTROL]);
      check("error_status", error_interrupt_status_o, m_est);
    end
  end

  task automatic idle();
    reset = 1'b1; adr_i = '0; reg_write_en = 0; reg_read_en = 0; byte_en = '0; data_i = '0;
    command_complete = 0; response_i = '0; normal_interrupt_event_i = '0;
    error_interrupt_event_i = '0; present_state_i = '0;
  endtask

  // Inputs are set at negedge+1; model steps, then the DUT clocks
  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    idle(); reg_write_en = 1; adr_i = 5'(a); data_i = d; byte_en = be; tick();
  endtask

  task automatic rd(input int a);
    idle(); reg_read_en = 1; adr_i = 5'(a); tick();
  endtask

  logic [31:0] rexp [4] = '{32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

  initial begin
    idle();
    @(negedge clock); #1;
    reset = 0; tick();
    mon_en = 1;
    reset = 0; tick();
    check("rst_block_size", block_size, 12'h0);
    check("rst_irq", interrupt, 1'b0);
    check("rst_valid", read_valid, 1'b0);

    // Byte lanes and 12-bit truncation
    wr(ADDR_BLOCK_SIZE, 32'h0000_FA00, 4'b0011);
    rd(ADDR_BLOCK_SIZE);
    check("bs_valid", read_valid, 1'b1);
    check("bs_trunc", data_o, 32'h0000_0A00);
    wr(ADDR_BLOCK_SIZE, 32'h1234_5677, 4'b0001);
    check("bs_lane0", block_size, 12'hA77);
    rd(ADDR_HOST_CONTROLLER_VERSION);
    check("version", data_o, 32'h0000_0002);
    rd(31);
    check("unmapped_valid", read_valid, 1'b1);
    check("unmapped_zero", data_o, 32'h0);
    idle(); reg_write_en = 1; reg_read_en = 1; adr_i = 5'(ADDR_ARGUMENT); data_i = 32'h55; byte_en = 4'hF; tick();
    check("rw_collide", read_valid, 1'b0);

    // Response capture and readback
    wr(ADDR_NORMAL_INT_STATUS_EN, 32'h1);
    idle(); command_complete = 1;
    response_i = 128'h1111_1111_2222_2222_3333_3333_4444_4444; tick();
    for (int k = 0; k < 4; k++) begin
      rd(ADDR_RESPONSE_BASE + k);
      check("resp_word", data_o, rexp[k]);
    end
    wr(ADDR_RESPONSE_BASE, 32'hFFFF_FFFF);
    rd(ADDR_RESPONSE_BASE);
    check("resp_ro", data_o, 32'h4444_4444);
    rd(ADDR_NORMAL_INT_STATUS);
    check("cc_status", data_o[0], 1'b1);

    // Error interrupt, set-wins and clear
    wr(ADDR_ERROR_INT_STATUS_EN, 32'h8);
    wr(ADDR_ERROR_INT_SIGNAL_EN, 32'h8);
    idle(); error_interrupt_event_i = 16'h0008; tick();
    check("irq_lag", interrupt, 1'b0);
    idle(); tick();
    check("irq_set", interrupt, 1'b1);
    idle(); reg_write_en = 1; adr_i = 5'(ADDR_ERROR_INT_STATUS); data_i = 32'h8; byte_en = 4'hF;
    error_interrupt_event_i = 16'h0008; tick();
    check("set_wins", error_interrupt_status_o[3], 1'b1);
    wr(ADDR_ERROR_INT_STATUS, 32'h8);
    check("w1c_clear", error_interrupt_status_o, 16'h0);
    idle(); tick();
    check("irq_drop", interrupt, 1'b0);

    // Command start and inhibit
    wr(ADDR_COMMAND, 32'h0000_0D1A);
    check("cmd_pulse", command_start, 1'b1);
    check("cmd_value", command, 16'h0D1A);
    idle(); tick();
    check("cmd_pulse_end", command_start, 1'b0);
    idle(); reg_write_en = 1; adr_i = 5'(ADDR_COMMAND); data_i = 32'h1234; byte_en = 4'hF;
    present_state_i = 16'h0001; tick();
    check("cmd_inhibit_val", command, 16'h0D1A);
    check("cmd_inhibit_pulse", command_start, 1'b0);

    // Software reset of everything
    wr(ADDR_ARGUMENT, 32'hDEAD_BEEF);
    check("arg_loaded", argument, 32'hDEAD_BEEF);
    wr(ADDR_SOFTWARE_RESET, 32'h1);
    check("swrst_c1", software_reset, 3'b001);
    wr(ADDR_SOFTWARE_RESET, 32'h6);
    check("swrst_c2", software_reset, 3'b001);
    idle(); tick();
    check("swrst_c3", software_reset, 3'b001);
    idle(); tick();
    check("swrst_c4", software_reset, 3'b001);
    idle(); tick();
    check("swrst_done", software_reset, 3'b000);
    check("swrst_arg", argument, 32'h0);

    // Hardware reset aborting an active sequence
    wr(ADDR_ARGUMENT, 32'hCAFE_F00D);
    wr(ADDR_SOFTWARE_RESET, 32'h5);
    idle(); tick();
    idle(); reset = 0; tick();
    check("hw_abort_sw", software_reset, 3'b000);
    check("hw_abort_arg", argument, 32'h0);
    idle(); tick();
    check("hw_abort_stays", software_reset, 3'b000);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      idle();
      if ($urandom_range(0, 399) == 0) reset = 0;
      r = $urandom_range(0, 9);
      adr_i = 5'($urandom_range(0, 31));
      data_i = $urandom;
      byte_en = 4'($urandom);
      if (r <= 3) reg_write_en = 1;
      else if (r <= 6) reg_read_en = 1;
      else if (r == 7) begin reg_write_en = 1; reg_read_en = 1; end
      command_complete = ($urandom_range(0, 7) == 0);
      response_i = {$urandom, $urandom, $urandom, $urandom};
      normal_interrupt_event_i = 16'($urandom & $urandom & $urandom);
      error_interrupt_event_i = 16'($urandom & $urandom & $urandom);
      present_state_i = 16'($urandom);
      tick();
    end

    idle(); tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
